// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder_pkg
// Description : Shared types and constants for the data-memory responder.
//               Used by the responder, its storage array, CPU top
//               integration and the bench.
//               - state_t           : responder FSM state encoding
//               - c_WORD_BYTES      : bytes per storage word
//               - idx_width()       : word-index width for a given depth
// Revision    : 1.0 - initial release
// ============================================================================
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int c_WORD_BYTES       = 4;
    localparam int c_DEPTH_WORDS_DFLT = 256;

    // Word-index width; clamped to 1 so a degenerate depth still yields a
    // legal vector width.
    function automatic int idx_width(input int depth_words);
        return (depth_words > 1) ? $clog2(depth_words) : 1;
    endfunction

    localparam int c_IDX_W_DFLT = idx_width(c_DEPTH_WORDS_DFLT);

endpackage : data_mem_responder_pkg
`default_nettype wire

// File: rtl/data_mem_responder_dmem_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_array
// Description : Single-port word array. Synchronous write, combinational
//               read at the same index. Contents are not affected by reset.
// Ports       : clk     - clock
//               i_we    - write enable (one word per edge)
//               i_idx   - word index for both read and write
//               i_wdata - write data
//               o_rdata - read data at i_idx (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule : dmem_array
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Memory-side end of the pipeline load/store interface.
//               Accepts one word-aligned request, waits LATENCY cycles,
//               then pulses ack_o for one cycle with read data or an error.
//               stall_o freezes the pipeline while an access is in flight.
// Ports       : clk_i   - clock
//               rst_i   - asynchronous active-low reset
//               req_i   - request valid (held until ack_o)
//               we_i    - 1 = write, 0 = read
//               addr_i  - byte address
//               wdata_i - write data
//               ack_o   - one-cycle completion pulse
//               rdata_o - read data, valid with ack_o on reads
//               err_o   - request faulted, valid with ack_o
//               stall_o - pipeline freeze request (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              ack_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o,
    output logic              stall_o
);

    localparam int c_IDX_W = idx_width(DEPTH_WORDS);
    localparam int c_OFS_W = $clog2(c_WORD_BYTES);
    localparam int c_CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LATENCY - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    state_t              r_state;
    state_t              w_next;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_IDX_W-1:0]  r_idx;
    logic                r_we;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_fault;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;

    logic                w_accept;
    logic                w_commit;
    logic                w_hi_nz;
    logic                w_fault_in;
    logic [c_IDX_W-1:0]  w_idx_in;
    logic [c_IDX_W-1:0]  w_c_idx;
    logic                w_c_we;
    logic                w_c_fault;
    logic [DATA_W-1:0]   w_c_wdata;
    logic [DATA_W-1:0]   w_mem_rdata;
    logic                w_mem_we;

    // ------------------------------------------------------------------
    // Fault check: byte offset must be zero and the word index must fit
    // in the array, i.e. every address bit above the index is zero.
    // ------------------------------------------------------------------
    assign w_idx_in = addr_i[c_IDX_W+c_OFS_W-1:c_OFS_W];

    generate
        if (ADDR_W > c_IDX_W + c_OFS_W) begin : g_upper_bits
            assign w_hi_nz = |addr_i[ADDR_W-1:c_IDX_W+c_OFS_W];
        end else begin : g_no_upper_bits
            assign w_hi_nz = 1'b0;
        end
    endgenerate

    assign w_fault_in = (|addr_i[c_OFS_W-1:0]) | w_hi_nz;

    assign w_accept = (r_state == IDLE) && req_i;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (req_i) begin
                    w_next = (LATENCY > 1) ? BUSY : RESP;
                end
            end
            BUSY: begin
                if (r_count == c_CNT_LAST) begin
                    w_next = RESP;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // The access commits on the edge that enters RESP. With LATENCY==1 that
    // edge is also the acceptance edge, so the request comes straight from
    // the inputs; otherwise the captured copies are used.
    assign w_commit  = (w_next == RESP) && (r_state != RESP);
    assign w_c_idx   = (r_state == IDLE) ? w_idx_in   : r_idx;
    assign w_c_we    = (r_state == IDLE) ? we_i       : r_we;
    assign w_c_wdata = (r_state == IDLE) ? wdata_i    : r_wdata;
    assign w_c_fault = (r_state == IDLE) ? w_fault_in : r_fault;
    assign w_mem_we  = w_commit && w_c_we && !w_c_fault;

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH_WORDS),
        .IDX_W  (c_IDX_W)
    ) u_dmem_array (
        .clk     (clk_i),
        .i_we    (w_mem_we),
        .i_idx   (w_c_idx),
        .i_wdata (w_c_wdata),
        .o_rdata (w_mem_rdata)
    );

    // ------------------------------------------------------------------
    // State, latency counter, captured request and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_count <= '0;
            r_idx   <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_fault <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;

            if (w_accept) begin
                r_idx   <= w_idx_in;
                r_we    <= we_i;
                r_wdata <= wdata_i;
                r_fault <= w_fault_in;
                r_count <= c_CNT_LOAD;
                r_err   <= 1'b0;
            end else if (r_state == BUSY) begin
                r_count <= r_count - c_CNT_ONE;
            end

            // Placed after the acceptance clear so a fault on a LATENCY==1
            // access (accept and commit on one edge) still sets err.
            if (w_commit) begin
                if (w_c_fault) begin
                    r_rdata <= '0;
                    r_err   <= 1'b1;
                end else if (!w_c_we) begin
                    r_rdata <= w_mem_rdata;
                end
            end
        end
    end

    assign ack_o   = (r_state == RESP);
    assign rdata_o = r_rdata;
    assign err_o   = r_err;
    // Low in RESP so the pipeline advances on the acknowledge cycle.
    assign stall_o = w_accept || (r_state == BUSY);

endmodule : data_mem_responder
`default_nettype wire
